// File: rtl/tlul_get_arbiter.sv
// tlul_get_arbiter
//   Shares one downstream TL-UL Get slave between NUM_HOSTS upstream hosts.
//   Round-robin arbitration, one transaction outstanding at a time. The grant
//   is held from A acceptance until the D handshake completes. Requests that
//   are not Get (opcode 4) are consumed and answered locally with an AccessAck,
//   so the single-outstanding slave never sees them.
//
//   Handshake rule used on every channel: a beat transfers on the rising clock
//   edge where valid and ready are both high. Valid never depends on ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   h_a_*                flattened per-host A channels (host i at [W*i +: W])
//   h_d_valid/h_d_ready  per-host D handshake
//   h_d_*                shared D fields, qualified by h_d_valid
//   a_*                  downstream A channel to the Get slave
//   d_*                  downstream D channel from the Get slave
module tlul_get_arbiter #(
    parameter int NUM_HOSTS = 2,
    parameter int GIDX_W    = $clog2(NUM_HOSTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_HOSTS-1:0]    h_a_valid,
    output logic [NUM_HOSTS-1:0]    h_a_ready,
    input  logic [3*NUM_HOSTS-1:0]  h_a_opcode,
    input  logic [3*NUM_HOSTS-1:0]  h_a_param,
    input  logic [4*NUM_HOSTS-1:0]  h_a_size,
    input  logic [4*NUM_HOSTS-1:0]  h_a_mask,
    input  logic [32*NUM_HOSTS-1:0] h_a_address,
    input  logic [32*NUM_HOSTS-1:0] h_a_data,
    input  logic [3*NUM_HOSTS-1:0]  h_a_source,
    output logic [NUM_HOSTS-1:0]    h_d_valid,
    input  logic [NUM_HOSTS-1:0]    h_d_ready,
    output logic [2:0]              h_d_opcode,
    output logic [2:0]              h_d_param,
    output logic [3:0]              h_d_size,
    output logic [31:0]             h_d_data,
    output logic [2:0]              h_d_source,
    output logic [1:0]              h_d_sink,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic [2:0]              a_opcode,
    output logic [2:0]              a_param,
    output logic [3:0]              a_size,
    output logic [3:0]              a_mask,
    output logic [31:0]             a_address,
    output logic [31:0]             a_data,
    output logic [2:0]              a_source,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [2:0]              d_opcode,
    input  logic [2:0]              d_param,
    input  logic [3:0]              d_size,
    input  logic [31:0]             d_data,
    input  logic [2:0]              d_source,
    input  logic [1:0]              d_sink
);

    localparam logic [2:0] OP_GET = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD_A  = 2'd1,
        ST_WAIT_D = 2'd2,
        ST_LOC_D  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [GIDX_W-1:0]  grant_q, grant_d;
    logic [GIDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    // Inside LOC_D: 0 on the consuming entry cycle, 1 while the ack is offered.
    logic               loc_rsp_q, loc_rsp_d;
    logic [3:0]         cap_size_q, cap_size_d;
    logic [2:0]         cap_source_q, cap_source_d;

    // Unflattened views of the host A fields, indexed by host number.
    logic [2:0]  opc_arr  [NUM_HOSTS];
    logic [2:0]  par_arr  [NUM_HOSTS];
    logic [3:0]  siz_arr  [NUM_HOSTS];
    logic [3:0]  msk_arr  [NUM_HOSTS];
    logic [31:0] adr_arr  [NUM_HOSTS];
    logic [31:0] dat_arr  [NUM_HOSTS];
    logic [2:0]  src_arr  [NUM_HOSTS];

    for (genvar i = 0; i < NUM_HOSTS; i++) begin : g_unpack
        assign opc_arr[i] = h_a_opcode[3*i +: 3];
        assign par_arr[i] = h_a_param[3*i +: 3];
        assign siz_arr[i] = h_a_size[4*i +: 4];
        assign msk_arr[i] = h_a_mask[4*i +: 4];
        assign adr_arr[i] = h_a_address[32*i +: 32];
        assign dat_arr[i] = h_a_data[32*i +: 32];
        assign src_arr[i] = h_a_source[3*i +: 3];
    end

    // Round-robin pick: first requesting host scanning rr_ptr, rr_ptr+1, ...
    // with wrap at NUM_HOSTS (not at a power of two).
    logic              arb_found;
    logic [GIDX_W-1:0] arb_idx;
    logic [GIDX_W-1:0] cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            if (!arb_found && h_a_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
            cand = (cand == GIDX_W'(NUM_HOSTS - 1)) ? '0 : cand + 1'b1;
        end
    end

    logic [GIDX_W-1:0] next_ptr;
    assign next_ptr = (grant_q == GIDX_W'(NUM_HOSTS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        loc_rsp_d    = loc_rsp_q;
        cap_size_d   = cap_size_q;
        cap_source_d = cap_source_q;

        h_a_ready  = '0;
        h_d_valid  = '0;
        h_d_opcode = '0;
        h_d_param  = '0;
        h_d_size   = '0;
        h_d_data   = '0;
        h_d_source = '0;
        h_d_sink   = '0;
        a_valid    = 1'b0;
        a_opcode   = '0;
        a_param    = '0;
        a_size     = '0;
        a_mask     = '0;
        a_address  = '0;
        a_data     = '0;
        a_source   = '0;
        d_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d   = arb_idx;
                    loc_rsp_d = 1'b0;
                    state_d   = (opc_arr[arb_idx] == OP_GET) ? ST_FWD_A : ST_LOC_D;
                end
            end

            ST_FWD_A: begin
                a_valid            = h_a_valid[grant_q];
                a_opcode           = opc_arr[grant_q];
                a_param            = par_arr[grant_q];
                a_size             = siz_arr[grant_q];
                a_mask             = msk_arr[grant_q];
                a_address          = adr_arr[grant_q];
                a_data             = dat_arr[grant_q];
                a_source           = src_arr[grant_q];
                h_a_ready[grant_q] = a_ready;
                // A host that drops valid early just leaves us waiting here.
                if (h_a_valid[grant_q] && a_ready) begin
                    state_d = ST_WAIT_D;
                end
            end

            ST_WAIT_D: begin
                h_d_valid[grant_q] = d_valid;
                h_d_opcode         = d_opcode;
                h_d_param          = d_param;
                h_d_size           = d_size;
                h_d_data           = d_data;
                h_d_source         = d_source;
                h_d_sink           = d_sink;
                d_ready            = h_d_ready[grant_q];
                if (d_valid && h_d_ready[grant_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end

            ST_LOC_D: begin
                if (!loc_rsp_q) begin
                    // Consume the non-Get request and remember what the ack echoes.
                    h_a_ready[grant_q] = 1'b1;
                    cap_size_d         = siz_arr[grant_q];
                    cap_source_d       = src_arr[grant_q];
                    loc_rsp_d          = 1'b1;
                end else begin
                    h_d_valid[grant_q] = 1'b1;
                    h_d_size           = cap_size_q;
                    h_d_source         = cap_source_q;
                    if (h_d_ready[grant_q]) begin
                        loc_rsp_d = 1'b0;
                        rr_ptr_d  = next_ptr;
                        state_d   = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            loc_rsp_q    <= 1'b0;
            cap_size_q   <= '0;
            cap_source_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            loc_rsp_q    <= loc_rsp_d;
            cap_size_q   <= cap_size_d;
            cap_source_q <= cap_source_d;
        end
    end

endmodule

// File: tb/tb_tlul_get_arbiter.sv
// Bench for tlul_get_arbiter with three hosts and a behavioural Get slave.
// The reference model works per transaction: round-robin choice among the
// hosts requesting at the arbitration point, and the response each host must
// receive (slave memory word under the byte mask, or a local AccessAck).
module tb_tlul_get_arbiter;

    localparam int NH = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NH-1:0]    h_a_valid, h_a_ready, h_d_valid, h_d_ready;
    logic [3*NH-1:0]  h_a_opcode, h_a_param, h_a_source;
    logic [4*NH-1:0]  h_a_size, h_a_mask;
    logic [32*NH-1:0] h_a_address, h_a_data;
    logic [2:0]       h_d_opcode, h_d_param, h_d_source;
    logic [3:0]       h_d_size;
    logic [31:0]      h_d_data;
    logic [1:0]       h_d_sink;
    logic             a_valid, a_ready, d_valid, d_ready;
    logic [2:0]       a_opcode, a_param, a_source, d_opcode, d_param, d_source;
    logic [3:0]       a_size, a_mask, d_size;
    logic [31:0]      a_address, a_data, d_data;
    logic [1:0]       d_sink;

    tlul_get_arbiter #(.NUM_HOSTS(NH)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_a_valid(h_a_valid), .h_a_ready(h_a_ready), .h_a_opcode(h_a_opcode),
        .h_a_param(h_a_param), .h_a_size(h_a_size), .h_a_mask(h_a_mask),
        .h_a_address(h_a_address), .h_a_data(h_a_data), .h_a_source(h_a_source),
        .h_d_valid(h_d_valid), .h_d_ready(h_d_ready), .h_d_opcode(h_d_opcode),
        .h_d_param(h_d_param), .h_d_size(h_d_size), .h_d_data(h_d_data),
        .h_d_source(h_d_source), .h_d_sink(h_d_sink),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
        .a_source(a_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_data(d_data), .d_source(d_source), .d_sink(d_sink)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem [16];
    // Entry = {host[1:0], opcode, param, size, data, source, sink}.
    logic [48:0] exp_q[$];
    int          grant_log[$];
    int          m_ptr;
    bit          arb_done;
    int          m_win;
    bit          m_get;
    logic [2:0]  r_op   [NH];
    logic [31:0] r_addr [NH];
    logic [3:0]  r_mask [NH];
    logic [2:0]  r_src  [NH];

    function automatic logic [31:0] mask32(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // The slave answers a Get with AccessAckData (opcode 1), sink = source[1:0].
    function automatic logic [46:0] model_rsp(input logic [2:0] op, input logic [3:0] size,
                                              input logic [31:0] addr, input logic [3:0] mask,
                                              input logic [2:0] src);
        if (op == 3'd4)
            return {3'd1, 3'd0, size, mem[addr[5:2]] & mask32(mask), src, src[1:0]};
        return {3'd0, 3'd0, size, 32'd0, src, 2'd0};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NH-1:0] req);
        for (int k = 0; k < NH; k++)
            if (req[(ptr + k) % NH]) return (ptr + k) % NH;
        return -1;
    endfunction

    function automatic int pending(input int h);
        int n = 0;
        foreach (exp_q[i]) if (int'(exp_q[i][48:47]) == h) n++;
        return n;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        m_ptr    = 0;
        arb_done = 0;
        m_win    = 0;
        m_get    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ptr    = 0;
                arb_done = 0;
            end else begin
                if (!arb_done && (h_a_valid != '0)) begin
                    m_win    = rr_pick(m_ptr, h_a_valid);
                    m_get    = (h_a_opcode[3*m_win +: 3] == 3'd4);
                    arb_done = 1;
                    grant_log.push_back(m_win);
                end
                check("hd_onehot", 64'($countones(h_d_valid) <= 1), 64'd1);
                if (h_a_ready != '0)
                    check("a_ready_who", 64'(h_a_ready), arb_done ? 64'(1 << m_win) : 64'd0);
                if (h_d_valid != '0)
                    check("d_valid_who", 64'(h_d_valid), arb_done ? 64'(1 << m_win) : 64'd0);
                if (a_valid)
                    check("a_valid_only_get", 64'(arb_done && m_get), 64'd1);
                if (a_valid && a_ready)
                    check("down_a_fields", {22'd0, a_opcode, a_address, a_mask, a_source},
                          {22'd0, 3'd4, r_addr[m_win], r_mask[m_win], r_src[m_win]});
                for (int h = 0; h < NH; h++) begin
                    if (h_d_valid[h] && h_d_ready[h]) begin
                        int fidx;
                        fidx = -1;
                        foreach (exp_q[i])
                            if (fidx < 0 && int'(exp_q[i][48:47]) == h) fidx = i;
                        if (fidx < 0) begin
                            check("unexpected_rsp", 64'(h), 64'hFF);
                        end else begin
                            check("rsp", {17'd0, h_d_opcode, h_d_param, h_d_size, h_d_data,
                                          h_d_source, h_d_sink}, {17'd0, exp_q[fidx][46:0]});
                            exp_q.delete(fidx);
                        end
                        m_ptr    = (h + 1) % NH;
                        arb_done = 0;
                    end
                end
            end
        end
    end

    // ---------------- behavioural Get slave ----------------
    logic        hs_a, hs_d;
    logic [31:0] s_addr;
    logic [3:0]  s_mask, s_size;
    logic [2:0]  s_src;
    int          s_delay;
    bit          s_busy;

    initial begin
        a_ready = 0; d_valid = 0; d_opcode = 0; d_param = 0; d_size = 0;
        d_data = 0; d_source = 0; d_sink = 0; s_busy = 0; s_delay = 0;
        s_addr = 0; s_mask = 0; s_size = 0; s_src = 0;
        forever begin
            @(negedge clk);
            hs_a = rst_n && a_valid && a_ready;
            hs_d = rst_n && d_valid && d_ready;
            if (hs_a) begin
                s_addr = a_address; s_mask = a_mask; s_size = a_size; s_src = a_source;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                a_ready = 0; d_valid = 0; s_busy = 0;
            end else if (hs_a) begin
                s_busy  = 1;
                a_ready = 0;
                s_delay = $urandom_range(0, 3);
            end else if (s_busy && !d_valid) begin
                if (s_delay == 0) begin
                    d_valid  = 1;
                    d_opcode = 3'd1;
                    d_param  = 3'd0;
                    d_size   = s_size;
                    d_data   = mem[s_addr[5:2]] & mask32(s_mask);
                    d_source = s_src;
                    d_sink   = s_src[1:0];
                end else begin
                    s_delay--;
                end
            end else if (d_valid && hs_d) begin
                d_valid = 0;
                s_busy  = 0;
            end
            if (rst_n && !s_busy) a_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- host D-ready driver ----------------
    logic [NH-1:0] rdy_hold;
    bit            rdy_rand;

    initial begin
        h_d_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            h_d_ready = (rdy_rand ? NH'($urandom) : {NH{1'b1}}) & ~rdy_hold;
        end
    end

    // ---------------- host driver tasks ----------------
    task automatic host_req(input int h, input logic [2:0] op, input logic [31:0] addr,
                            input logic [3:0] mask, input logic [3:0] size, input logic [2:0] src);
        int  t;
        bit  done;
        @(posedge clk);
        #1;
        r_op[h] = op; r_addr[h] = addr; r_mask[h] = mask; r_src[h] = src;
        exp_q.push_back({2'(h), model_rsp(op, size, addr, mask, src)});
        h_a_opcode[3*h +: 3]   = op;
        h_a_param[3*h +: 3]    = 3'd0;
        h_a_size[4*h +: 4]     = size;
        h_a_mask[4*h +: 4]     = mask;
        h_a_address[32*h +: 32] = addr;
        h_a_data[32*h +: 32]   = $urandom;
        h_a_source[3*h +: 3]   = src;
        h_a_valid[h]           = 1'b1;
        t    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (h_a_valid[h] && h_a_ready[h]) done = 1;
            else if (++t > 300) begin
                check("accept_timeout", 64'(h), 64'hFF);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        h_a_valid[h] = 1'b0;
    endtask

    task automatic wait_resp(input int h);
        int t = 0;
        while (pending(h) > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("resp_arrived", 64'(pending(h)), 64'd0);
    endtask

    task automatic host_loop(input int h, input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = $urandom_range(0, 9);
            host_req(h, (r < 6) ? 3'd4 : ((r < 8) ? 3'd0 : 3'd1),
                     {26'd0, 4'($urandom), 2'b00}, 4'($urandom_range(1, 15)),
                     4'd2, 3'($urandom));
            wait_resp(h);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        h_a_valid = '0; h_a_opcode = '0; h_a_param = '0; h_a_size = '0; h_a_mask = '0;
        h_a_address = '0; h_a_data = '0; h_a_source = '0;
        rdy_hold = '0;
        rdy_rand = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[4] = 32'h1A2B3C4F;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_h_a_ready", 64'(h_a_ready), 64'd0);
        check("rst_h_d_valid", 64'(h_d_valid), 64'd0);
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_d_ready", 64'(d_ready), 64'd0);
        check("rst_h_d_data", 64'(h_d_data), 64'd0);

        // Single Get from host0.
        host_req(0, 3'd4, 32'h10, 4'hF, 4'd2, 3'd3);
        wait_resp(0);

        // Two hosts competing from rr_ptr=0: grants alternate.
        reset_dut();
        grant_log.delete();
        fork
            begin
                host_req(0, 3'd4, 32'h10, 4'hF, 4'd2, 3'd3); wait_resp(0);
                host_req(0, 3'd4, 32'h10, 4'hF, 4'd2, 3'd3); wait_resp(0);
            end
            begin
                host_req(1, 3'd4, 32'h10, 4'h3, 4'd2, 3'd1); wait_resp(1);
                host_req(1, 3'd4, 32'h10, 4'h3, 4'd2, 3'd1); wait_resp(1);
            end
        join
        check("alt_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("alt_grant", 64'(grant_log[i]), 64'(i % 2));

        // Local PutFullData from host1.
        host_req(1, 3'd0, 32'h20, 4'hF, 4'd2, 3'd5);
        wait_resp(1);

        // D back-pressure on host0 while host1 waits.
        rdy_hold = 3'b001;
        fork host_req(0, 3'd4, 32'h10, 4'hF, 4'd2, 3'd3); join_none
        begin
            int t = 0;
            while (!h_d_valid[0] && t < 100) begin @(negedge clk); t++; end
        end
        check("stall_reached", 64'(h_d_valid[0]), 64'd1);
        begin
            logic [31:0] held;
            held = h_d_data;
            fork host_req(1, 3'd4, 32'h14, 4'hF, 4'd2, 3'd2); join_none
            repeat (5) begin
                @(negedge clk);
                check("stall_d_ready", 64'(d_ready), 64'd0);
                check("stall_h_d_valid", 64'(h_d_valid[0]), 64'd1);
                check("stall_data", 64'(h_d_data), 64'(held));
                check("stall_h1_ready", 64'(h_a_ready[1]), 64'd0);
            end
        end
        rdy_hold = '0;
        wait_resp(0);
        wait_resp(1);
        wait fork;

        // Reset while waiting for D.
        reset_dut();
        rdy_hold = 3'b001;
        fork host_req(0, 3'd4, 32'h10, 4'hF, 4'd2, 3'd3); join_none
        wait fork;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_h_a_ready", 64'(h_a_ready), 64'd0);
        check("arst_h_d_valid", 64'(h_d_valid), 64'd0);
        check("arst_a_valid", 64'(a_valid), 64'd0);
        check("arst_d_ready", 64'(d_ready), 64'd0);
        exp_q.delete();
        rdy_hold = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_log.delete();
        host_req(1, 3'd4, 32'h18, 4'hF, 4'd2, 3'd6);
        wait_resp(1);
        check("post_rst_grant", grant_log.size() > 0 ? 64'(grant_log[0]) : 64'hFF, 64'd1);

        // Randomized traffic from all hosts with random D back-pressure.
        rdy_rand = 1;
        for (int h = 0; h < NH; h++) begin
            automatic int hh = h;
            fork host_loop(hh, 20); join_none
        end
        wait fork;
        rdy_rand = 0;

        check("all_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
